// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Parameterised serial sequence detector. Compares the most recent `len`
//   valid bits of a 1-bit stream against a run-time loadable pattern and
//   emits a registered one-cycle match pulse per hit. The detector supports
//   overlapping and non-overlapping detection. A saturating counter tallies
//   the hits.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   din          serial data bit
//   din_valid    din is sampled only when high
//   cfg_we       one-cycle strobe loading cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern  new pattern; bit[len-1] is the first bit received, bit[0] the last
//   cfg_len      new pattern length (clamped to 1..MAX_LEN)
//   cfg_overlap  1 = overlapping, 0 = non-overlapping detection
//   cnt_clr      clears match_count (wins over a simultaneous hit)
//   match        registered one-cycle pulse per detected pattern
//   match_count  saturating number of matches
//   cur_len      active (clamped) pattern length
module seq_detect_param #(
    parameter int unsigned          MAX_LEN         = 8,
    parameter int unsigned          LEN_W           = $clog2(MAX_LEN + 1),
    parameter int unsigned          CNT_W           = 8,
    parameter logic [MAX_LEN-1:0]   DEFAULT_PATTERN = MAX_LEN'(8'b0000_0110),
    parameter int unsigned          DEFAULT_LEN     = 4,
    parameter bit                   DEFAULT_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   cur_len
);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q,    hist_d;
    logic [LEN_W-1:0]   fill_q,    fill_d;
    logic               match_q,   match_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;

    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] len_mask;
    logic               window_full;
    logic               pattern_eq;
    logic               hit;
    logic [LEN_W-1:0]   len_clamped;

    always_comb begin
        hist_next = {hist_q[MAX_LEN-2:0], din};

        // Only the low len bits of history/pattern take part in the compare.
        len_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < 32'(len_q));
        end

        // One extra bit so fill+1 cannot wrap when MAX_LEN+1 is a power of two.
        window_full = (({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_q});
        pattern_eq  = (((hist_next ^ pattern_q) & len_mask) == '0);
        hit         = din_valid & ~cfg_we & window_full & pattern_eq;

        if (cfg_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (cfg_len > LEN_W'(MAX_LEN)) begin
            len_clamped = LEN_W'(MAX_LEN);
        end else begin
            len_clamped = cfg_len;
        end
    end

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        cnt_d     = cnt_q;

        if (cfg_we) begin
            // A valid bit arriving with the config strobe is discarded.
            pattern_d = cfg_pattern;
            len_d     = len_clamped;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
        end else if (din_valid) begin
            hist_d  = hist_next;
            match_d = hit;
            if (hit && !overlap_q) begin
                fill_d = '0;
            end else if (fill_q < len_q) begin
                fill_d = fill_q + 1'b1;
            end
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= DEFAULT_PATTERN;
            len_q     <= LEN_W'(DEFAULT_LEN);
            overlap_q <= DEFAULT_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
        end
    end

    assign match       = match_q;
    assign match_count = cnt_q;
    assign cur_len     = len_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param
//   Scoreboard bench for seq_detect_param. Two instances share one stimulus
//   stream: the default build (CNT_W=8) and a CNT_W=2 build for saturation.
//   Stimulus pushes the reference model's expected outputs for each cycle into
//   a queue; an independent monitor pops and compares after every clock edge.
module tb_seq_detect_param;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned LEN_W   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               din;
    logic               din_valid;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               match,  match2;
    logic [7:0]         match_count;
    logic [1:0]         match_count2;
    logic [LEN_W-1:0]   cur_len, cur_len2;

    always #5 clk = ~clk;

    seq_detect_param #(.MAX_LEN(8), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match(match), .match_count(match_count), .cur_len(cur_len)
    );

    seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match(match2), .match_count(match_count2), .cur_len(cur_len2)
    );

    typedef struct packed {
        logic       m;
        logic [7:0] c8;
        logic [1:0] c2;
        logic [3:0] l;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: the stream of valid bits since the last restart,
    // compared as a list against the pattern read first-bit-first.
    logic [7:0] pat_m;
    int         len_m;
    bit         ov_m;
    bit         stream[$];
    int         cnt8_m, cnt2_m;

    task automatic cyc(input bit rst, input bit d, input bit dv, input bit we,
                       input logic [7:0] pat, input logic [3:0] ln,
                       input bit ov, input bit clr);
        bit   hit;
        int   n;
        exp_t e;
        reset = rst; din = d; din_valid = dv; cfg_we = we;
        cfg_pattern = pat; cfg_len = ln; cfg_overlap = ov; cnt_clr = clr;
        hit = 1'b0;
        if (rst) begin
            pat_m = 8'b0000_0110; len_m = 4; ov_m = 1'b1;
            stream.delete(); cnt8_m = 0; cnt2_m = 0;
        end else begin
            if (we) begin
                pat_m = pat; ov_m = ov;
                len_m = (ln == 0) ? 1 : ((int'(ln) > MAX_LEN) ? MAX_LEN : int'(ln));
                stream.delete();
            end else if (dv) begin
                stream.push_back(d);
                while (stream.size() > MAX_LEN) void'(stream.pop_front());
                n = stream.size();
                if (n >= len_m) begin
                    hit = 1'b1;
                    for (int k = 0; k < len_m; k++)
                        if (stream[n - len_m + k] != pat_m[len_m - 1 - k]) hit = 1'b0;
                end
                if (hit && !ov_m) stream.delete();
            end
            if (clr) begin
                cnt8_m = 0; cnt2_m = 0;
            end else if (hit) begin
                if (cnt8_m < 255) cnt8_m++;
                if (cnt2_m < 3)   cnt2_m++;
            end
        end
        e.m = hit; e.c8 = 8'(cnt8_m); e.c2 = 2'(cnt2_m); e.l = 4'(len_m);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic bitv(input bit d);
        cyc(0, d, 1, 0, 8'h00, 4'd0, 0, 0);
    endtask

    task automatic gap();
        cyc(0, 1'($urandom), 0, 0, 8'h00, 4'd0, 0, 0);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] ln, input bit ov);
        cyc(0, 0, 0, 1, pat, ln, ov, 0);
    endtask

    task automatic bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bitv(v[i]);
    endtask

    // Monitor: every edge produces an output sample from both instances.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (match !== e.m) begin
                    errors++; $display("FAIL match: got %0b want %0b at %0t", match, e.m, $time);
                end
                checks++;
                if (match_count !== e.c8) begin
                    errors++; $display("FAIL match_count: got %0d want %0d at %0t", match_count, e.c8, $time);
                end
                checks++;
                if (cur_len !== e.l) begin
                    errors++; $display("FAIL cur_len: got %0d want %0d at %0t", cur_len, e.l, $time);
                end
                checks++;
                if (match2 !== e.m) begin
                    errors++; $display("FAIL match2: got %0b want %0b at %0t", match2, e.m, $time);
                end
                checks++;
                if (match_count2 !== e.c2) begin
                    errors++; $display("FAIL match_count2: got %0d want %0d at %0t", match_count2, e.c2, $time);
                end
                checks++;
                if (cur_len2 !== e.l) begin
                    errors++; $display("FAIL cur_len2: got %0d want %0d at %0t", cur_len2, e.l, $time);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int drain;
        // 1: reset, default 0110 overlapping
        cyc(1, 0, 0, 0, 8'h00, 4'd0, 0, 0);
        cyc(1, 1, 1, 1, 8'hFF, 4'd7, 0, 1);
        bits(16'b0011_0110_0110, 12);
        // 2: non-overlap vs overlap on 0110110
        load(8'b0000_0110, 4'd4, 0);
        bits(16'b011_0110, 7);
        load(8'b0000_0110, 4'd4, 1);
        bits(16'b011_0110, 7);
        // 3: 8-bit pattern with a 3-cycle gap, then length clamping
        load(8'b1011_0011, 4'd8, 1);
        bits(16'b10110, 5);
        gap(); gap(); gap();
        bits(16'b011, 3);
        load(8'b1011_0011, 4'd12, 1);
        bits(16'b1011_0011, 8);
        load(8'b0000_0001, 4'd0, 1);
        bits(16'b1011, 4);
        // 4: config strobe with a valid bit mid-pattern
        load(8'b0000_0110, 4'd4, 1);
        bits(16'b011, 3);
        cyc(0, 0, 1, 1, 8'b0000_0110, 4'd4, 1, 0);
        bits(16'b0110, 4);
        // 5: saturation of the CNT_W=2 instance, then clear against a hit
        cyc(0, 0, 0, 0, 8'h00, 4'd0, 0, 1);
        load(8'b0000_0001, 4'd1, 0);
        bits(16'b11111, 5);
        cyc(0, 1, 1, 0, 8'h00, 4'd0, 0, 1);
        bits(16'b0101, 4);
        // 6: reset mid-pattern
        load(8'b0000_0110, 4'd4, 1);
        bits(16'b011, 3);
        cyc(1, 0, 1, 0, 8'h00, 4'd0, 0, 0);
        bitv(0);
        bits(16'b0110, 4);
        // Randomised traffic with occasional reconfiguration, clears and resets
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r == 0) begin
                cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 0);
            end else if (r < 5) begin
                cyc(0, 1'($urandom), 1'($urandom), 1, 8'($urandom),
                    (r == 1) ? 4'($urandom) : 4'($urandom_range(0, 5)), 1'($urandom), 1'($urandom_range(0, 7) == 0));
            end else begin
                cyc(0, 1'($urandom), ($urandom_range(0, 3) != 0), 0, 8'($urandom), 4'($urandom),
                    1'($urandom), ($urandom_range(0, 63) == 0));
            end
        end
        cyc(0, 0, 0, 0, 8'h00, 4'd0, 0, 0);
        drain = 0;
        while (exp_q.size() != 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
